// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the MIPS-style instruction decode stage.
package decode_stage_pkg;

  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int RADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] v);
    return {{(XLEN-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32 x 32 register file: two combinational read ports, one write port, $0 hardwired to zero.
module reg_file
  import decode_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]    rdata1,
  output logic [XLEN-1:0]    rdata2,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]    wdata
);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic                      arm_reg;
  logic                      wr_en;
  logic                      byp1;
  logic                      byp2;

  // Writes stay blocked until one edge after reset release, so a write
  // landing on the deassertion edge cannot leak into the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arm_reg <= 1'b0;
    else     arm_reg <= 1'b1;
  end

  assign wr_en = we && (waddr != '0) && arm_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_q[gi] = '0;
      end else begin : g_word
        logic [XLEN-1:0] word_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst)
            word_reg <= '0;
          else if (wr_en && (waddr == RADDR_W'(gi)))
            word_reg <= wdata;
        end
        assign regs_q[gi] = word_reg;
      end
    end
  endgenerate

  // Write-through: a read of the register being written sees the new data.
  assign byp1 = wr_en && (raddr1 == waddr);
  assign byp2 = wr_en && (raddr2 == waddr);

  assign rdata1 = byp1 ? wdata : regs_q[raddr1];
  assign rdata2 = byp2 ? wdata : regs_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: control decode, register read, sign extension and ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    if_id_instr,
  input  logic [XLEN-1:0]    if_id_npc,
  input  logic               mem_wb_reg_write,
  input  logic [RADDR_W-1:0] mem_wb_write_reg,
  input  logic [XLEN-1:0]    mem_wb_write_data,
  output logic [WB_W-1:0]    id_ex_wb,
  output logic [M_W-1:0]     id_ex_m,
  output logic [EX_W-1:0]    id_ex_ex,
  output logic [XLEN-1:0]    id_ex_npc,
  output logic [XLEN-1:0]    id_ex_rd1,
  output logic [XLEN-1:0]    id_ex_rd2,
  output logic [XLEN-1:0]    id_ex_imm,
  output logic [RADDR_W-1:0] id_ex_rt,
  output logic [RADDR_W-1:0] id_ex_rd
);

  logic [5:0]         opcode;
  logic [RADDR_W-1:0] rs_idx;
  logic [RADDR_W-1:0] rt_idx;
  logic [RADDR_W-1:0] rd_idx;
  logic [XLEN-1:0]    rd1_data;
  logic [XLEN-1:0]    rd2_data;
  ctrl_t              ctrl_next;

  logic [WB_W-1:0]    wb_next,  wb_reg;
  logic [M_W-1:0]     m_next,   m_reg;
  logic [EX_W-1:0]    ex_next,  ex_reg;
  logic [XLEN-1:0]    imm_next, imm_reg;
  logic [XLEN-1:0]    npc_reg;
  logic [XLEN-1:0]    rd1_reg;
  logic [XLEN-1:0]    rd2_reg;
  logic [RADDR_W-1:0] rt_reg;
  logic [RADDR_W-1:0] rd_reg;

  assign opcode = if_id_instr[31:26];
  assign rs_idx = if_id_instr[25:21];
  assign rt_idx = if_id_instr[20:16];
  assign rd_idx = if_id_instr[15:11];

  reg_file u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs_idx),
    .raddr2 (rt_idx),
    .rdata1 (rd1_data),
    .rdata2 (rd2_data),
    .we     (mem_wb_reg_write),
    .waddr  (mem_wb_write_reg),
    .wdata  (mem_wb_write_data)
  );

  // Unknown opcodes fall through to all-zero control so they have no effect.
  always_comb begin
    ctrl_next = CTRL_NONE;
    case (opcode)
      OP_RTYPE: begin
        ctrl_next.reg_dst   = 1'b1;
        ctrl_next.reg_write = 1'b1;
        ctrl_next.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_next.alu_src    = 1'b1;
        ctrl_next.mem_to_reg = 1'b1;
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_read   = 1'b1;
        ctrl_next.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_next.alu_src   = 1'b1;
        ctrl_next.mem_write = 1'b1;
        ctrl_next.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_next.branch = 1'b1;
        ctrl_next.alu_op = ALUOP_SUB;
      end
      default: ctrl_next = CTRL_NONE;
    endcase
  end

  assign wb_next  = {ctrl_next.reg_write, ctrl_next.mem_to_reg};
  assign m_next   = {ctrl_next.branch, ctrl_next.mem_read, ctrl_next.mem_write};
  assign ex_next  = {ctrl_next.reg_dst, ctrl_next.alu_op, ctrl_next.alu_src};
  assign imm_next = sign_ext16(if_id_instr[15:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_reg  <= '0;
      m_reg   <= '0;
      ex_reg  <= '0;
      npc_reg <= '0;
      rd1_reg <= '0;
      rd2_reg <= '0;
      imm_reg <= '0;
      rt_reg  <= '0;
      rd_reg  <= '0;
    end else begin
      wb_reg  <= wb_next;
      m_reg   <= m_next;
      ex_reg  <= ex_next;
      npc_reg <= if_id_npc;
      rd1_reg <= rd1_data;
      rd2_reg <= rd2_data;
      imm_reg <= imm_next;
      rt_reg  <= rt_idx;
      rd_reg  <= rd_idx;
    end
  end

  assign id_ex_wb  = wb_reg;
  assign id_ex_m   = m_reg;
  assign id_ex_ex  = ex_reg;
  assign id_ex_npc = npc_reg;
  assign id_ex_rd1 = rd1_reg;
  assign id_ex_rd2 = rd2_reg;
  assign id_ex_imm = imm_reg;
  assign id_ex_rt  = rt_reg;
  assign id_ex_rd  = rd_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] mem_wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_rd1;
  logic [31:0] id_ex_rd2;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;

  int vectors = 0;
  int errors  = 0;

  decode_stage dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_instr       (if_id_instr),
    .if_id_npc         (if_id_npc),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_write_reg  (mem_wb_write_reg),
    .mem_wb_write_data (mem_wb_write_data),
    .id_ex_wb          (id_ex_wb),
    .id_ex_m           (id_ex_m),
    .id_ex_ex          (id_ex_ex),
    .id_ex_npc         (id_ex_npc),
    .id_ex_rd1         (id_ex_rd1),
    .id_ex_rd2         (id_ex_rd2),
    .id_ex_imm         (id_ex_imm),
    .id_ex_rt          (id_ex_rt),
    .id_ex_rd          (id_ex_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb"},  32'(id_ex_wb),  32'h0);
    check({tag, "_m"},   32'(id_ex_m),   32'h0);
    check({tag, "_ex"},  32'(id_ex_ex),  32'h0);
    check({tag, "_npc"}, id_ex_npc,      32'h0);
    check({tag, "_rd1"}, id_ex_rd1,      32'h0);
    check({tag, "_rd2"}, id_ex_rd2,      32'h0);
    check({tag, "_imm"}, id_ex_imm,      32'h0);
    check({tag, "_rt"},  32'(id_ex_rt),  32'h0);
    check({tag, "_rd"},  32'(id_ex_rd),  32'h0);
  endtask

  initial begin
    // Reset held with busy, non-zero inputs.
    rst               = 1'b1;
    if_id_instr       = 32'h8C49_FFFC;
    if_id_npc         = 32'h0000_1234;
    mem_wb_reg_write  = 1'b1;
    mem_wb_write_reg  = 5'd5;
    mem_wb_write_data = 32'hFFFF_FFFF;
    step();
    step();
    step();
    check_all_zero("reset_hold");
    $display("reset held: outputs checked");

    // Release with a write of $5 on the deassertion edge; it must be dropped.
    rst               = 1'b0;
    mem_wb_reg_write  = 1'b1;
    mem_wb_write_reg  = 5'd5;
    mem_wb_write_data = 32'h5555_5555;
    if_id_instr       = 32'h00A5_0000;
    if_id_npc         = 32'h0000_0100;
    step();
    mem_wb_reg_write  = 1'b0;
    check("first_edge_npc", id_ex_npc, 32'h0000_0100);
    check("first_edge_rd1", id_ex_rd1, 32'h0);
    check("first_edge_wb",  32'(id_ex_wb), 32'(2'b10));
    $display("release: first edge npc=%h rd1=%h", id_ex_npc, id_ex_rd1);

    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      if_id_instr = {6'h00, r, r, 5'd0, 11'd0};
      if_id_npc   = 32'h0000_0200 + 32'(i * 4);
      step();
      check("post_reset_rs", id_ex_rd1, 32'h0);
      check("post_reset_rt", id_ex_rd2, 32'h0);
    end
    $display("registers $1..$31 read after reset");

    // Write $8 then read it as rs of add $10,$8,$9.
    mem_wb_reg_write  = 1'b1;
    mem_wb_write_reg  = 5'd8;
    mem_wb_write_data = 32'h0000_1234;
    if_id_instr       = 32'h0000_0000;
    step();
    mem_wb_reg_write  = 1'b0;
    if_id_instr       = 32'h0109_5020;
    if_id_npc         = 32'h0000_0400;
    step();
    check("add_rd1", id_ex_rd1, 32'h0000_1234);
    check("add_rd2", id_ex_rd2, 32'h0);
    check("add_wb",  32'(id_ex_wb), 32'(2'b10));
    check("add_m",   32'(id_ex_m),  32'(3'b000));
    check("add_ex",  32'(id_ex_ex), 32'(4'b1100));
    check("add_rd",  32'(id_ex_rd), 32'd10);
    check("add_rt",  32'(id_ex_rt), 32'd9);
    check("add_npc", id_ex_npc, 32'h0000_0400);
    $display("add $10,$8,$9: rd1=%h ex=%b", id_ex_rd1, id_ex_ex);

    // Same-cycle write of $9 while reading rt=9.
    mem_wb_reg_write  = 1'b1;
    mem_wb_write_reg  = 5'd9;
    mem_wb_write_data = 32'hDEAD_BEEF;
    step();
    mem_wb_reg_write  = 1'b0;
    check("bypass_rd2", id_ex_rd2, 32'hDEAD_BEEF);
    check("bypass_rd1", id_ex_rd1, 32'h0000_1234);
    step();
    check("stored_rd2", id_ex_rd2, 32'hDEAD_BEEF);
    $display("bypass: rd2=%h", id_ex_rd2);

    // Writes to $0 are dropped, with or without bypass.
    mem_wb_reg_write  = 1'b1;
    mem_wb_write_reg  = 5'd0;
    mem_wb_write_data = 32'hFFFF_FFFF;
    if_id_instr       = 32'h0000_0000;
    step();
    mem_wb_reg_write  = 1'b0;
    check("zero_bypass_rd1", id_ex_rd1, 32'h0);
    check("nop_wb", 32'(id_ex_wb), 32'(2'b10));
    check("nop_ex", 32'(id_ex_ex), 32'(4'b1100));
    step();
    check("zero_read_rd1", id_ex_rd1, 32'h0);
    $display("$0 write: rd1=%h", id_ex_rd1);

    // lw $9,-4($2)
    if_id_instr = 32'h8C49_FFFC;
    if_id_npc   = 32'h0000_0500;
    step();
    check("lw_imm", id_ex_imm, 32'hFFFF_FFFC);
    check("lw_m",   32'(id_ex_m),  32'(3'b010));
    check("lw_wb",  32'(id_ex_wb), 32'(2'b11));
    check("lw_ex",  32'(id_ex_ex), 32'(4'b0001));
    check("lw_rt",  32'(id_ex_rt), 32'd9);
    check("lw_rd2", id_ex_rd2, 32'hDEAD_BEEF);
    check("lw_npc", id_ex_npc, 32'h0000_0500);
    $display("lw: imm=%h m=%b wb=%b ex=%b", id_ex_imm, id_ex_m, id_ex_wb, id_ex_ex);

    // sw $9,16($2)
    if_id_instr = 32'hAC49_0010;
    step();
    check("sw_m",   32'(id_ex_m),  32'(3'b001));
    check("sw_imm", id_ex_imm, 32'h0000_0010);
    check("sw_wb",  32'(id_ex_wb), 32'(2'b00));
    check("sw_ex",  32'(id_ex_ex), 32'(4'b0001));
    $display("sw: m=%b imm=%h", id_ex_m, id_ex_imm);

    // beq $2,$9,3
    if_id_instr = 32'h1049_0003;
    step();
    check("beq_m",   32'(id_ex_m),  32'(3'b100));
    check("beq_ex",  32'(id_ex_ex), 32'(4'b0010));
    check("beq_wb",  32'(id_ex_wb), 32'(2'b00));
    check("beq_imm", id_ex_imm, 32'h0000_0003);
    $display("beq: m=%b ex=%b", id_ex_m, id_ex_ex);

    // Unknown opcode (j) decodes to no control activity.
    if_id_instr = 32'h0800_0040;
    step();
    check("unk_wb", 32'(id_ex_wb), 32'h0);
    check("unk_m",  32'(id_ex_m),  32'h0);
    check("unk_ex", 32'(id_ex_ex), 32'h0);
    $display("unknown opcode: wb=%b m=%b ex=%b", id_ex_wb, id_ex_m, id_ex_ex);

    // Mid-run asynchronous reset between edges.
    if_id_instr = 32'h0109_5020;
    if_id_npc   = 32'h0000_0600;
    step();
    check("pre_rst_rd1", id_ex_rd1, 32'h0000_1234);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    $display("mid-run reset: outputs checked before next edge");
    step();
    rst = 1'b0;
    step();
    step();
    check("post_mid_rst_rd1", id_ex_rd1, 32'h0);
    check("post_mid_rst_rd2", id_ex_rd2, 32'h0);
    check("post_mid_rst_wb",  32'(id_ex_wb), 32'(2'b10));
    $display("after mid-run reset: rd1=%h rd2=%h", id_ex_rd1, id_ex_rd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
